// File: rtl/confreg_sram_resp_if.sv
// confreg_sram_resp_if: data_sram access port between the core (master) and a memory-mapped slave.
// Byte write enables of 4'b0000 mark a read; rdata is returned one cycle after the read strobe.
interface confreg_sram_resp_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/confreg_sram_resp.sv
// confreg_sram_resp: 64 KB MMIO configuration-register window on the core's data_sram port.
// Build option: define CONFREG_TIMER_EN to include TIMER/COMPARE/STATUS and the timer_int source.
module confreg_sram_resp #(
  parameter logic [31:0] BASE_ADDR = 32'hBFAF_0000,
  parameter int unsigned LED_W     = 16,
  parameter int unsigned SW_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  confreg_sram_resp_if.slave  data_sram,
  input  logic [SW_W-1:0]     switch_in,
  output logic [LED_W-1:0]    led_out,
  output logic [31:0]         num_out,
  output logic                timer_int
);

  localparam logic [15:0] OFF_TIMER   = 16'h0000;
  localparam logic [15:0] OFF_COMPARE = 16'h0004;
  localparam logic [15:0] OFF_STATUS  = 16'h0008;
  localparam logic [15:0] OFF_LED     = 16'h000C;
  localparam logic [15:0] OFF_SWITCH  = 16'h0010;
  localparam logic [15:0] OFF_NUM     = 16'h0014;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_TIMER,
    REG_COMPARE,
    REG_STATUS,
    REG_LED,
    REG_SWITCH,
    REG_NUM
  } reg_sel_e;

  logic             hit;
  logic             aligned;
  logic             access;
  logic             rd_strobe;
  logic             wr_access;
  reg_sel_e         sel;

  logic [31:0]      rd_value;
  logic [31:0]      rdata_q;
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] led_d;
  logic [31:0]      num_q;
  logic [SW_W-1:0]  sw_meta_q;
  logic [SW_W-1:0]  sw_sync_q;
  logic [31:0]      led_ext;
  logic [31:0]      sw_ext;

  // Only bytes whose enable is set take the new value.
  function automatic logic [31:0] byte_merge(input logic [31:0] base,
                                             input logic [31:0] wr,
                                             input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = be[i] ? wr[i*8 +: 8] : base[i*8 +: 8];
    end
    return r;
  endfunction

  assign hit       = (data_sram.data_sram_addr[31:16] == BASE_ADDR[31:16]);
  assign aligned   = (data_sram.data_sram_addr[1:0] == 2'b00);
  assign access    = data_sram.data_sram_en && hit && aligned;
  // Any read strobe updates rdata, so misses and unaligned reads return 0 rather than stale data.
  assign rd_strobe = data_sram.data_sram_en && (data_sram.data_sram_wen == 4'b0000);
  assign wr_access = access && (data_sram.data_sram_wen != 4'b0000);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel = REG_NONE;
    if (access) begin
      case (data_sram.data_sram_addr[15:0])
`ifdef CONFREG_TIMER_EN
        OFF_TIMER:   sel = REG_TIMER;
        OFF_COMPARE: sel = REG_COMPARE;
        OFF_STATUS:  sel = REG_STATUS;
`endif
        OFF_LED:     sel = REG_LED;
        OFF_SWITCH:  sel = REG_SWITCH;
        OFF_NUM:     sel = REG_NUM;
        default:     sel = REG_NONE;
      endcase
    end
  end

`ifdef CONFREG_TIMER_EN
  logic [31:0] timer_q;
  logic [31:0] timer_inc;
  logic [31:0] timer_d;
  logic [31:0] compare_q;
  logic [31:0] compare_d;
  logic        ie_q;
  logic        ie_d;
  logic        pend_q;
  logic        pend_d;
  logic        int_q;
  logic        wr_timer;
  logic        wr_compare;
  logic        wr_status;
  logic        pend_set;
  logic        pend_clr;

  always_comb begin
    wr_timer   = wr_access && (sel == REG_TIMER);
    wr_compare = wr_access && (sel == REG_COMPARE);
    wr_status  = wr_access && (sel == REG_STATUS);

    // Written timer bytes override the incremented value; unwritten bytes keep counting.
    timer_inc = timer_q + 32'd1;
    timer_d   = wr_timer ? byte_merge(timer_inc, data_sram.data_sram_wdata, data_sram.data_sram_wen)
                         : timer_inc;
    compare_d = wr_compare ? byte_merge(compare_q, data_sram.data_sram_wdata, data_sram.data_sram_wen)
                           : compare_q;

    ie_d = ie_q;
    if (wr_status && data_sram.data_sram_wen[0]) begin
      ie_d = data_sram.data_sram_wdata[0];
    end

    // A match wins over a same-cycle W1C; writes to TIMER/COMPARE mask the match that cycle.
    pend_set = ie_q && (timer_q == compare_q) && !wr_timer && !wr_compare;
    pend_clr = wr_status && data_sram.data_sram_wen[0] && data_sram.data_sram_wdata[1];
    pend_d   = pend_set ? 1'b1 : (pend_clr ? 1'b0 : pend_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      timer_q   <= 32'h0000_0000;
      compare_q <= 32'hFFFF_FFFF;
      ie_q      <= 1'b0;
      pend_q    <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      compare_q <= compare_d;
      ie_q      <= ie_d;
      pend_q    <= pend_d;
      int_q     <= pend_q & ie_q;
    end
  end

  assign timer_int = int_q;
`else
  assign timer_int = 1'b0;
`endif

  always_comb begin
    led_ext = '0;
    led_ext[LED_W-1:0] = led_q;
    sw_ext = '0;
    sw_ext[SW_W-1:0] = sw_sync_q;
  end

  always_comb begin
    led_d = led_q;
    if (wr_access && (sel == REG_LED)) begin
      for (int i = 0; i < LED_W; i++) begin
        if (data_sram.data_sram_wen[i / 8]) begin
          led_d[i] = data_sram.data_sram_wdata[i];
        end
      end
    end
  end

  always_comb begin
    rd_value = '0;
    case (sel)
`ifdef CONFREG_TIMER_EN
      REG_TIMER:   rd_value = timer_q;
      REG_COMPARE: rd_value = compare_q;
      REG_STATUS:  rd_value = {30'd0, pend_q, ie_q};
`endif
      REG_LED:     rd_value = led_ext;
      REG_SWITCH:  rd_value = sw_ext;
      REG_NUM:     rd_value = num_q;
      default:     rd_value = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      led_q     <= '0;
      num_q     <= '0;
      rdata_q   <= '0;
    end else begin
      sw_meta_q <= switch_in;
      sw_sync_q <= sw_meta_q;
      led_q     <= led_d;
      if (wr_access && (sel == REG_NUM)) begin
        num_q <= byte_merge(num_q, data_sram.data_sram_wdata, data_sram.data_sram_wen);
      end
      if (rd_strobe) begin
        rdata_q <= rd_value;
      end
    end
  end

  assign data_sram.data_sram_rdata = rdata_q;
  assign led_out = led_q;
  assign num_out = num_q;

endmodule

// File: tb/tb_confreg_sram_resp.sv
// tb_confreg_sram_resp: directed bench for confreg_sram_resp; read data is checked by a
// scoreboard monitor, register outputs are checked inline.
module tb_confreg_sram_resp;

  localparam logic [31:0] A_TIMER   = 32'hBFAF_0000;
  localparam logic [31:0] A_COMPARE = 32'hBFAF_0004;
  localparam logic [31:0] A_STATUS  = 32'hBFAF_0008;
  localparam logic [31:0] A_LED     = 32'hBFAF_000C;
  localparam logic [31:0] A_SWITCH  = 32'hBFAF_0010;
  localparam logic [31:0] A_NUM     = 32'hBFAF_0014;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  switch_in;
  logic [15:0] led_out;
  logic [31:0] num_out;
  logic        timer_int;
  logic        rd_fire = 1'b0;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  confreg_sram_resp_if sram_if ();

  confreg_sram_resp dut (
    .clk       (clk),
    .rst       (rst),
    .data_sram (sram_if),
    .switch_in (switch_in),
    .led_out   (led_out),
    .num_out   (num_out),
    .timer_int (timer_int)
  );

  always #5 clk = ~clk;

`ifdef CONFREG_TIMER_EN
  // Reference cycle count since reset release; equals the expected free-running timer.
  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= rst ? cyc + 32'd1 : 32'd0;
`endif

  always @(posedge clk) begin
    rd_fire <= rst && sram_if.data_sram_en && (sram_if.data_sram_wen == 4'b0000);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: one rdata comparison for every read strobe, one cycle after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_fire) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_read: got %h with no expected value queued",
                   sram_if.data_sram_rdata);
        end else begin
          e = exp_q.pop_front();
          check(e.name, sram_if.data_sram_rdata, e.data);
        end
      end
    end
  end

  task automatic idle(input int n);
    sram_if.data_sram_en  = 1'b0;
    sram_if.data_sram_wen = 4'b0000;
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] data);
    sram_if.data_sram_en    = 1'b1;
    sram_if.data_sram_wen   = wen;
    sram_if.data_sram_addr  = addr;
    sram_if.data_sram_wdata = data;
    @(negedge clk);
    sram_if.data_sram_en    = 1'b0;
    sram_if.data_sram_wen   = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] addr, input string name, input logic [31:0] expv);
    exp_t e;
    e.name = name;
    e.data = expv;
    exp_q.push_back(e);
    sram_if.data_sram_en    = 1'b1;
    sram_if.data_sram_wen   = 4'b0000;
    sram_if.data_sram_addr  = addr;
    sram_if.data_sram_wdata = 32'd0;
    @(negedge clk);
    sram_if.data_sram_en    = 1'b0;
  endtask

  initial begin
    rst                     = 1'b0;
    switch_in               = 8'h00;
    sram_if.data_sram_en    = 1'b0;
    sram_if.data_sram_wen   = 4'b0000;
    sram_if.data_sram_addr  = 32'd0;
    sram_if.data_sram_wdata = 32'd0;
    repeat (3) @(negedge clk);

    check("reset_rdata", sram_if.data_sram_rdata, 32'd0);
    check("reset_led", 32'(led_out), 32'd0);
    check("reset_num", num_out, 32'd0);
    check("reset_int", 32'(timer_int), 32'd0);
    rst = 1'b1;

`ifdef CONFREG_TIMER_EN
    idle(5);
    bus_read(A_TIMER, "timer_count", cyc);
    bus_read(A_COMPARE, "compare_reset", 32'hFFFF_FFFF);
    bus_read(A_STATUS, "status_reset", 32'd0);

    bus_write(A_TIMER, 4'hF, 32'h1234_5600);
    bus_write(A_TIMER, 4'b0010, 32'h0000_7700);
    bus_read(A_TIMER, "timer_merge", 32'h1234_7701);

    bus_write(A_COMPARE, 4'hF, 32'h0000_0020);
    bus_write(A_STATUS, 4'h1, 32'h0000_0001);
    bus_write(A_TIMER, 4'hF, 32'h0000_0000);
    idle(33);
    check("int_latency", 32'(timer_int), 32'd0);
    idle(1);
    check("int_assert", 32'(timer_int), 32'd1);
    bus_read(A_STATUS, "status_pend", 32'd3);
    bus_write(A_STATUS, 4'h1, 32'h0000_0003);
    idle(1);
    check("int_clear", 32'(timer_int), 32'd0);

    bus_write(A_TIMER, 4'hF, 32'h0000_001E);
    idle(2);
    bus_write(A_STATUS, 4'h1, 32'h0000_0003);
    bus_read(A_STATUS, "w1c_set_wins", 32'd3);
    check("int_set_wins", 32'(timer_int), 32'd1);

    bus_write(A_STATUS, 4'h1, 32'h0000_0000);
    bus_read(A_STATUS, "pend_kept", 32'd2);
    idle(1);
    check("int_ie_off", 32'(timer_int), 32'd0);

    bus_write(A_TIMER, 4'hF, 32'hFFFF_FFFF);
    bus_read(A_TIMER, "timer_max", 32'hFFFF_FFFF);
    bus_read(A_TIMER, "timer_wrap", 32'd0);
`else
    bus_read(A_TIMER, "timer_absent", 32'd0);
    bus_read(A_COMPARE, "compare_absent", 32'd0);
    bus_write(A_STATUS, 4'hF, 32'h0000_0001);
    bus_read(A_STATUS, "status_absent", 32'd0);
`endif

    bus_write(A_LED, 4'b0011, 32'h1234_ABCD);
    check("led_write", 32'(led_out), 32'h0000_ABCD);
    bus_read(A_LED, "led_readback", 32'h0000_ABCD);
    bus_write(A_LED, 4'b0010, 32'h0000_5500);
    check("led_byte1", 32'(led_out), 32'h0000_55CD);

    bus_write(A_NUM, 4'hF, 32'h1122_3344);
    bus_write(A_NUM, 4'b0100, 32'h00EE_0000);
    bus_read(A_NUM, "num_merge", 32'h11EE_3344);
    check("num_out", num_out, 32'h11EE_3344);
    idle(3);
    check("rdata_hold", sram_if.data_sram_rdata, 32'h11EE_3344);

    bus_read(32'hBFAE_0000, "window_miss", 32'd0);
    bus_read(A_NUM, "num_again", 32'h11EE_3344);
    bus_read(32'hBFAF_0015, "unaligned_rd", 32'd0);
    bus_write(32'hBFAF_0015, 4'hF, 32'hDEAD_BEEF);
    bus_write(32'hBFAE_0014, 4'hF, 32'hCAFE_F00D);
    check("num_untouched", num_out, 32'h11EE_3344);
    bus_write(32'hBFAF_0018, 4'hF, 32'hFFFF_FFFF);
    bus_read(32'hBFAF_0018, "unmapped", 32'd0);

    switch_in = 8'h5A;
    bus_read(A_SWITCH, "sw_sync0", 32'd0);
    bus_read(A_SWITCH, "sw_sync1", 32'd0);
    bus_read(A_SWITCH, "sw_sync2", 32'h0000_005A);
    bus_write(A_SWITCH, 4'hF, 32'd0);
    bus_read(A_SWITCH, "sw_readonly", 32'h0000_005A);

    bus_write(A_LED, 4'hF, 32'hFFFF_0F0F);
    bus_read(A_LED, "led_upper_zero", 32'h0000_0F0F);
`ifndef CONFREG_TIMER_EN
    check("int_tied_low", 32'(timer_int), 32'd0);
`endif

    // Reset lands on the same edge as a NUM write: the write must be dropped.
    rst = 1'b0;
    bus_write(A_NUM, 4'hF, 32'hDEAD_BEEF);
    check("midreset_num", num_out, 32'd0);
    check("midreset_led", 32'(led_out), 32'd0);
    check("midreset_rdata", sram_if.data_sram_rdata, 32'd0);
    check("midreset_int", 32'(timer_int), 32'd0);
    rst = 1'b1;
    idle(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
